// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point FFT butterfly sequencer.
package fft4_pkg;

    // One complex sample: signed Q15 real part in the upper half, imaginary part in the lower half.
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // Twiddle factors used by a 4-point DIT: 1+j0 and 0-j1 in Q15.
    localparam cplx_t W0 = {16'sd32767, 16'sd0};
    localparam cplx_t W1 = {16'sd0, -16'sd32767};

    // Sequencer phases: collect samples, four butterfly passes, stream results out.
    typedef enum logic [2:0] {
        LOAD,
        C0,
        C1,
        C2,
        C3,
        DRAIN
    } state_t;

endpackage

// File: rtl/fft4_butterfly.sv
// Combinational radix-2 butterfly: out0 = A + W*B, out1 = A - W*B, Q15 product rounded to nearest.
module fft4_butterfly
    import fft4_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_w,
    output logic [31:0] o_out0,
    output logic [31:0] o_out1
);

    cplx_t w_a;
    cplx_t w_b;
    cplx_t w_w;
    cplx_t w_out0;
    cplx_t w_out1;
    logic signed [33:0] w_prodRe;
    logic signed [33:0] w_prodIm;
    logic signed [15:0] w_wbRe;
    logic signed [15:0] w_wbIm;

    assign w_a = i_a;
    assign w_b = i_b;
    assign w_w = i_w;

    // Full-precision complex product plus half an LSB so the shift rounds instead of truncating.
    assign w_prodRe = w_w.re * w_b.re - w_w.im * w_b.im + 34'sd16384;
    assign w_prodIm = w_w.re * w_b.im + w_w.im * w_b.re + 34'sd16384;
    assign w_wbRe   = 16'(w_prodRe >>> 15);
    assign w_wbIm   = 16'(w_prodIm >>> 15);

    assign w_out0.re = w_a.re + w_wbRe;
    assign w_out0.im = w_a.im + w_wbIm;
    assign w_out1.re = w_a.re - w_wbRe;
    assign w_out1.im = w_a.im - w_wbIm;

    assign o_out0 = w_out0;
    assign o_out1 = w_out1;

endmodule

// File: rtl/fft4_regfile.sv
// Four-entry sample store with two combinational read ports and two synchronous write ports.
module fft4_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_rdAddr0,
    input  logic [1:0]       i_rdAddr1,
    output logic [WIDTH-1:0] o_rdData0,
    output logic [WIDTH-1:0] o_rdData1,
    input  logic             i_wrEn0,
    input  logic [1:0]       i_wrAddr0,
    input  logic [WIDTH-1:0] i_wrData0,
    input  logic             i_wrEn1,
    input  logic [1:0]       i_wrAddr1,
    input  logic [WIDTH-1:0] i_wrData1
);

    logic [WIDTH-1:0] r_mem [4];

    // Clear on reset, otherwise apply both write ports; port 1 wins if both target one entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_wrEn0) begin
                r_mem[i_wrAddr0] <= i_wrData0;
            end
            if (i_wrEn1) begin
                r_mem[i_wrAddr1] <= i_wrData1;
            end
        end
    end

    assign o_rdData0 = r_mem[i_rdAddr0];
    assign o_rdData1 = r_mem[i_rdAddr1];

endmodule

// File: rtl/fft4_bf_sequencer.sv
// Drives one shared external butterfly through a complete 4-point DIT FFT, frame by frame.
module fft4_bf_sequencer
    import fft4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_out0,
    input  logic [WIDTH-1:0] bf_out1
);

    state_t           r_state;
    logic [1:0]       r_loadCnt;
    logic [1:0]       r_drainCnt;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_outLast;
    logic             r_busy;

    logic             w_hsIn;
    logic             w_hsOut;
    logic             w_opActive;
    logic [1:0]       w_addrA;
    logic [1:0]       w_addrB;
    logic [WIDTH-1:0] w_twiddle;
    logic [WIDTH-1:0] w_rdA;
    logic [WIDTH-1:0] w_rdB;
    logic             w_wrEn0;
    logic [1:0]       w_wrAddr0;
    logic [WIDTH-1:0] w_wrData0;

    assign w_hsIn  = in_valid & r_inReady;
    assign w_hsOut = r_outValid & out_ready;

    // Choose which register pair feeds the butterfly in each compute pass; in DRAIN the A port
    // reads results in bit-reversed register order so X0..X3 leave in natural order.
    always_comb begin
        w_addrA    = 2'd0;
        w_addrB    = 2'd2;
        w_twiddle  = W0;
        w_opActive = 1'b0;
        case (r_state)
            C0: begin
                w_addrA    = 2'd0;
                w_addrB    = 2'd2;
                w_opActive = 1'b1;
            end
            C1: begin
                w_addrA    = 2'd1;
                w_addrB    = 2'd3;
                w_opActive = 1'b1;
            end
            C2: begin
                w_addrA    = 2'd0;
                w_addrB    = 2'd1;
                w_opActive = 1'b1;
            end
            C3: begin
                w_addrA    = 2'd2;
                w_addrB    = 2'd3;
                w_twiddle  = W1;
                w_opActive = 1'b1;
            end
            DRAIN: begin
                w_addrA = {r_drainCnt[0], r_drainCnt[1]};
            end
            default: begin
            end
        endcase
    end

    // Write port 0 loads incoming samples in LOAD and takes the A+W*B result during compute.
    always_comb begin
        w_wrEn0   = 1'b0;
        w_wrAddr0 = w_addrA;
        w_wrData0 = bf_out0;
        if (r_state == LOAD) begin
            w_wrEn0   = w_hsIn;
            w_wrAddr0 = r_loadCnt;
            w_wrData0 = in_data;
        end else if (w_opActive) begin
            w_wrEn0 = 1'b1;
        end
    end

    fft4_regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rdAddr0 (w_addrA),
        .i_rdAddr1 (w_addrB),
        .o_rdData0 (w_rdA),
        .o_rdData1 (w_rdB),
        .i_wrEn0   (w_wrEn0),
        .i_wrAddr0 (w_wrAddr0),
        .i_wrData0 (w_wrData0),
        .i_wrEn1   (w_opActive),
        .i_wrAddr1 (w_addrB),
        .i_wrData1 (bf_out1)
    );

    // Frame sequencing: count samples in, step through the four passes, count results out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_loadCnt  <= 2'd0;
            r_drainCnt <= 2'd0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_hsIn) begin
                        r_loadCnt <= r_loadCnt + 2'd1;
                        if (r_loadCnt == 2'd3) begin
                            r_state   <= C0;
                            r_inReady <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                C0: r_state <= C1;
                C1: r_state <= C2;
                C2: r_state <= C3;
                C3: begin
                    r_state    <= DRAIN;
                    r_drainCnt <= 2'd0;
                    r_outValid <= 1'b1;
                    r_outLast  <= 1'b0;
                end
                DRAIN: begin
                    if (w_hsOut) begin
                        r_drainCnt <= r_drainCnt + 2'd1;
                        r_outLast  <= (r_drainCnt == 2'd2);
                        if (r_drainCnt == 2'd3) begin
                            r_state    <= LOAD;
                            r_loadCnt  <= 2'd0;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                            r_inReady  <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign busy      = r_busy;
    assign out_data  = r_outValid ? w_rdA : '0;
    assign bf_a      = w_opActive ? w_rdA : '0;
    assign bf_b      = w_opActive ? w_rdB : '0;
    assign bf_w      = w_twiddle;

endmodule

// File: tb/tb_fft4_bf_sequencer.sv
// Self-checking bench for fft4_bf_sequencer wired to the real butterfly.
module tb_fft4_bf_sequencer;
    import fft4_pkg::*;

    typedef struct {
        string           name;
        logic [3:0][31:0] x;
        logic [3:0][31:0] X;
        int              stallMode;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic [31:0] bf_a;
    logic [31:0] bf_b;
    logic [31:0] bf_w;
    logic [31:0] bf_out0;
    logic [31:0] bf_out1;

    int nCompared   = 0;
    int nMismatched = 0;

    vec_t vecs [4];

    fft4_bf_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .bf_w      (bf_w),
        .bf_out0   (bf_out0),
        .bf_out1   (bf_out1)
    );

    fft4_butterfly u_bf (
        .i_a    (bf_a),
        .i_b    (bf_b),
        .i_w    (bf_w),
        .o_out0 (bf_out0),
        .o_out1 (bf_out1)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] cw(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {r, i};
    endfunction

    // Reference 4-point DFT: X[k] = sum x[n] * (-j)^(k*n), evaluated directly.
    function automatic logic [3:0][31:0] dft4(input logic [3:0][31:0] x);
        logic [3:0][31:0] res;
        int accRe, accIm, sr, si;
        for (int k = 0; k < 4; k++) begin
            accRe = 0;
            accIm = 0;
            for (int n = 0; n < 4; n++) begin
                sr = int'($signed(x[n][31:16]));
                si = int'($signed(x[n][15:0]));
                case ((k * n) % 4)
                    0: begin accRe += sr; accIm += si; end
                    1: begin accRe += si; accIm -= sr; end
                    2: begin accRe -= sr; accIm -= si; end
                    default: begin accRe -= si; accIm += sr; end
                endcase
            end
            res[k] = cw(accRe, accIm);
        end
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " out_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " bf_a"}, bf_a, 32'd0);
        checkOutput({tag, " bf_b"}, bf_b, 32'd0);
        checkOutput({tag, " bf_w"}, bf_w, W0);
    endtask

    task automatic loadFrame(input logic [3:0][31:0] x, input bit gaps);
        int  n, g;
        logic hs;
        n = 0;
        g = 0;
        in_data = x[0];
        while (n < 4 && g < 200) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = in_valid & in_ready;
            tick;
            g++;
            if (hs) begin
                n++;
                if (n < 4) in_data = x[n];
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (n < 4) failTimeout("load");
    endtask

    task automatic drainFrame(input int stallMode, input bit checkLat, output logic [3:0][31:0] got);
        int   i, k, p, g;
        logic hsO, holding, hLast;
        logic [31:0] hData;
        logic [3:0]  lasts;
        logic [0:6]  pat;
        pat = 7'b1001011;
        out_ready = 1'b1;
        i = 0;
        while (!out_valid && i < 12) begin
            if (checkLat && i < 4) begin
                checkOutput($sformatf("bf_w pass%0d", i), bf_w, (i == 3) ? W1 : W0);
                checkOutput($sformatf("in_ready pass%0d", i), 32'(in_ready), 32'd0);
                checkOutput($sformatf("busy pass%0d", i), 32'(busy), 32'd1);
            end
            tick;
            i++;
        end
        if (checkLat) checkOutput("latency", 32'(i), 32'd4);
        k = 0; p = 0; g = 0;
        holding = 1'b0; hLast = 1'b0; hData = '0;
        lasts = '0;
        got = '0;
        while (k < 4 && g < 60) begin
            case (stallMode)
                0: out_ready = 1'b1;
                1: out_ready = pat[p % 7];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            p++;
            if (holding) begin
                checkOutput("stall data", out_data, hData);
                checkOutput("stall last", 32'(out_last), 32'(hLast));
                checkOutput("stall valid", 32'(out_valid), 32'd1);
            end
            checkOutput("in_ready drain", 32'(in_ready), 32'd0);
            hsO = out_valid & out_ready;
            if (hsO) begin
                got[k]   = out_data;
                lasts[k] = out_last;
                k++;
                holding = 1'b0;
            end else if (out_valid) begin
                holding = 1'b1;
                hData   = out_data;
                hLast   = out_last;
            end
            tick;
            g++;
        end
        out_ready = 1'b1;
        if (k < 4) failTimeout("drain");
        checkOutput("out_last pattern", 32'(lasts), 32'b1000);
        checkOutput("in_ready after", 32'(in_ready), 32'd1);
        checkOutput("busy after", 32'(busy), 32'd0);
        checkOutput("out_valid after", 32'(out_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [3:0][31:0] x, input int stallMode, input bit gaps,
                                 output logic [3:0][31:0] got);
        loadFrame(x, gaps);
        drainFrame(stallMode, 1'b1, got);
    endtask

    task automatic compareFrame(input string name, input logic [3:0][31:0] got, input logic [3:0][31:0] exp);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s X%0d", name, k), got[k], exp[k]);
        end
    endtask

    initial begin
        logic [3:0][31:0] got;
        logic [3:0][31:0] rx;
        int   hsCount;
        logic hs;

        vecs[0].name = "ramp";
        vecs[0].x = {cw(4, 0), cw(3, 0), cw(2, 0), cw(1, 0)};
        vecs[0].X = {cw(-2, -2), cw(-2, 0), cw(-2, 2), cw(10, 0)};
        vecs[0].stallMode = 0;
        vecs[1].name = "complex";
        vecs[1].x = {cw(0, 0), cw(0, 0), cw(20, 15), cw(10, 5)};
        vecs[1].X = {cw(-5, 25), cw(-10, -10), cw(25, -15), cw(30, 20)};
        vecs[1].stallMode = 0;
        vecs[2].name = "ramp_stall";
        vecs[2].x = vecs[0].x;
        vecs[2].X = vecs[0].X;
        vecs[2].stallMode = 1;
        vecs[3].name = "impulse";
        vecs[3].x = {cw(0, 0), cw(0, 0), cw(0, 0), cw(100, 0)};
        vecs[3].X = {cw(100, 0), cw(100, 0), cw(100, 0), cw(100, 0)};
        vecs[3].stallMode = 0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        tick;
        tick;
        checkReset("reset");
        rst = 1'b0;
        tick;

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].x, vecs[v].stallMode, 1'b0, got);
            compareFrame(vecs[v].name, got, vecs[v].X);
        end

        // in_valid held high across a whole frame: only four samples may be taken.
        in_valid = 1'b1;
        hsCount = 0;
        in_data = vecs[0].x[0];
        for (int c = 0; c < 8; c++) begin
            hs = in_ready;
            if (hsCount >= 4) begin
                checkOutput("in_ready hold", 32'(in_ready), 32'd0);
                checkOutput("busy hold", 32'(busy), 32'd1);
            end
            tick;
            if (hs) begin
                hsCount++;
                if (hsCount < 4) in_data = vecs[0].x[hsCount];
                else in_data = 32'hDEAD_BEEF;
            end
        end
        in_valid = 1'b0;
        checkOutput("consumed", 32'(hsCount), 32'd4);
        drainFrame(0, 1'b0, got);
        compareFrame("hold_valid", got, vecs[0].X);

        // Reset after two samples.
        in_valid = 1'b1;
        hsCount = 0;
        in_data = vecs[0].x[0];
        for (int c = 0; c < 10 && hsCount < 2; c++) begin
            hs = in_ready;
            tick;
            if (hs) begin
                hsCount++;
                in_data = vecs[0].x[hsCount];
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkReset("rst midload");

        // Reset in the C2 pass, after checking the operands presented there.
        loadFrame(vecs[0].x, 1'b0);
        tick;
        tick;
        checkOutput("C2 bf_a", bf_a, cw(4, 0));
        checkOutput("C2 bf_b", bf_b, cw(6, 0));
        checkOutput("C2 bf_w", bf_w, W0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkReset("rst C2");

        applyStimulus(vecs[0].x, 0, 1'b0, got);
        compareFrame("after_rst", got, vecs[0].X);

        // Random frames against the direct DFT model, with input gaps and random sink stalls.
        for (int f = 0; f < 12; f++) begin
            for (int n = 0; n < 4; n++) begin
                rx[n] = cw($urandom_range(0, 8000) - 4000, $urandom_range(0, 8000) - 4000);
            end
            applyStimulus(rx, 2, 1'b1, got);
            compareFrame($sformatf("rand%0d", f), got, dft4(rx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
